sobel_rgb2y_feeder: RTL

Producer side of the Sobel input stream. Accepts packed 24-bit RGB pixels over valid/ready, converts each to 8-bit luma (Y) in a 2-stage pipeline, and buffers the results in a small FIFO. It then drives the 8-bit valid/ready stream that the Sobel control block consumes. Frame sequencing counts IMG_W*IMG_H pixels per start pulse and tags end-of-line and end-of-frame.

---
 rtl/sobel_pkg.sv | 34 +++
 rtl/sobel_rgb2y_feeder_if.sv | 32 +++
 rtl/sobel_sync_fifo.sv | 68 ++++++
 rtl/sobel_rgb2y_feeder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared constants and types for the Sobel input-stream feeder.
//   RGB_W / Y_W       : packed pixel width in, luma width out
//   COEF_* / ROUND    : BT.601-style 8-bit fixed-point luma weights
//   state_e           : feeder frame sequencing states
//   fifo_entry_t      : one buffered output word {eof, eol, y}
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int RGB_W = 24;
    localparam int Y_W   = 8;

    // Weights sum to 256, so Y = weighted sum >> 8 never exceeds 255.
    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;
    localparam int ROUND  = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic           eof;
        logic           eol;
        logic [Y_W-1:0] y;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/sobel_rgb2y_feeder_if.sv
// -----------------------------------------------------------------------------
// sobel_rgb2y_feeder_if
// Bundles the two valid/ready streams around the feeder.
//   s_rgb_*  : 24-bit RGB pixel stream into the feeder
//   y_*      : 8-bit luma stream (with eol/eof tags) out to the Sobel block
// Modports:
//   master : the feeder itself (sinks RGB, sources luma)
//   slave  : the environment (sources RGB, sinks luma)
// -----------------------------------------------------------------------------
interface sobel_rgb2y_feeder_if;
    import sobel_pkg::*;

    logic [RGB_W-1:0] s_rgb_data;
    logic             s_rgb_valid;
    logic             s_rgb_ready;
    logic [Y_W-1:0]   y_data;
    logic             y_valid;
    logic             y_ready;
    logic             y_eol;
    logic             y_eof;

    modport master (
        input  s_rgb_data, s_rgb_valid, y_ready,
        output s_rgb_ready, y_data, y_valid, y_eol, y_eof
    );

    modport slave (
        output s_rgb_data, s_rgb_valid, y_ready,
        input  s_rgb_ready, y_data, y_valid, y_eol, y_eof
    );

endinterface

// File: rtl/sobel_sync_fifo.sv
// -----------------------------------------------------------------------------
// sobel_sync_fifo
// First-word-fall-through synchronous FIFO. dout always shows the head entry;
// a word pushed into an empty FIFO becomes visible the cycle after the push.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (pointers/count only)
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : consume head entry (ignored when empty)
//   dout         : head entry
//   count        : number of stored entries (0..DEPTH)
//   full, empty  : status flags
// -----------------------------------------------------------------------------
module sobel_sync_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count/pointers define which
    // entries are meaningful, and resetting an array costs a mux per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/sobel_rgb2y_feeder.sv
// -----------------------------------------------------------------------------
// sobel_rgb2y_feeder
// Accepts RGB pixels, converts them to 8-bit luma in a 2-stage pipeline and
// buffers them in a FWFT FIFO feeding the Sobel control block. Each start
// pulse sequences one IMG_W x IMG_H frame and tags end-of-line/end-of-frame.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : one-cycle pulse, begins a frame when idle
//   bus         : RGB input stream and tagged luma output stream
//   busy        : high whenever a frame is being accepted or drained
//   frame_done  : one-cycle pulse once the last pixel has left the FIFO
// -----------------------------------------------------------------------------
module sobel_rgb2y_feeder
    import sobel_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    sobel_rgb2y_feeder_if.master bus,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_STREAM = STREAM;
    localparam logic [1:0] ST_DRAIN  = DRAIN;

    logic [1:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    // Stage 1: per-channel products
    logic          s1_v, s1_eol, s1_eof;
    logic [14:0]   s1_pr;
    logic [15:0]   s1_pg;
    logic [14:0]   s1_pb;

    // Stage 2: rounded sum
    logic          s2_v, s2_eol, s2_eof;
    logic [16:0]   s2_sum;
    logic          s2_sum_unused;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full_unused;
    fifo_entry_t   fifo_din;
    fifo_entry_t   fifo_head;

    logic [CW:0]   in_flight;
    logic          accept;
    logic          last_x, last_y;
    logic          drained;

    // Credits count everything already committed to the FIFO, so the
    // pipeline can run without a stall path and the FIFO can never overflow.
    assign in_flight       = {1'b0, fifo_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
    assign bus.s_rgb_ready = (state == ST_STREAM) && (in_flight < (CW+1)'(FIFO_DEPTH));
    assign accept          = bus.s_rgb_valid && bus.s_rgb_ready;

    assign last_x  = (x == XW'(IMG_W - 1));
    assign last_y  = (y == YW'(IMG_H - 1));
    assign drained = !s1_v && !s2_v && fifo_empty;
    assign busy    = (state != ST_IDLE);

    // Frame sequencing and pixel coordinates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_STREAM;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (last_x) begin
                            x <= '0;
                            if (last_y) begin
                                y     <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pipeline valids and tags: cleared by reset so in-flight pixels are lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_eol <= 1'b0;
            s1_eof <= 1'b0;
            s2_v   <= 1'b0;
            s2_eol <= 1'b0;
            s2_eof <= 1'b0;
        end else begin
            s1_v   <= accept;
            s1_eol <= last_x;
            s1_eof <= last_x && last_y;
            s2_v   <= s1_v;
            s2_eol <= s1_eol;
            s2_eof <= s1_eof;
        end
    end

    // Datapath: only qualified by the valids above, so no reset needed
    always_ff @(posedge clk) begin
        s1_pr  <= 15'(bus.s_rgb_data[23:16]) * 15'(COEF_R);
        s1_pg  <= 16'(bus.s_rgb_data[15:8])  * 16'(COEF_G);
        s1_pb  <= 15'(bus.s_rgb_data[7:0])   * 15'(COEF_B);
        s2_sum <= 17'(s1_pr) + 17'(s1_pg) + 17'(s1_pb) + 17'(ROUND);
    end

    // Weights sum to 256: the sum never reaches bit 16 and the low byte is
    // the discarded fraction.
    assign s2_sum_unused = ^{s2_sum[16], s2_sum[7:0]};

    assign fifo_din.eof = s2_eof;
    assign fifo_din.eol = s2_eol;
    assign fifo_din.y   = s2_sum[15:8];

    sobel_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2_v),
        .din   (fifo_din),
        .pop   (bus.y_valid && bus.y_ready),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full_unused),
        .empty (fifo_empty)
    );

    // Outputs read zero while empty so stale storage never reaches the bus.
    assign bus.y_valid = !fifo_empty;
    assign bus.y_data  = bus.y_valid ? fifo_head.y   : '0;
    assign bus.y_eol   = bus.y_valid ? fifo_head.eol : 1'b0;
    assign bus.y_eof   = bus.y_valid ? fifo_head.eof : 1'b0;

endmodule
